// File: rtl/alu_sequencer.sv
// ALU sequencer: accepts commands, drives an external combinational ALU,
// and returns one response per accepted command.
//
// Ports:
//   clk_i, rst_n_i           clock, async active-low reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_op_i, cmd_a_i/b_i    opcode (0-7 ALU ops, 8 mul, 9-15 illegal), operands
//   alu_a_o/alu_b_o          operands to the external ALU
//   alu_control_o            3-bit ALU op code, zero-extended
//   alu_s_i, alu_flags_i     ALU result and {N,Z,C,V}, same cycle
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_result_o, rsp_flags_o, rsp_err_o  response payload
module alu_sequencer #(
    parameter int BITS = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [3:0]      cmd_op_i,
    input  logic [BITS-1:0] cmd_a_i,
    input  logic [BITS-1:0] cmd_b_i,
    output logic [BITS-1:0] alu_a_o,
    output logic [BITS-1:0] alu_b_o,
    output logic [BITS:0]   alu_control_o,
    input  logic [BITS-1:0] alu_s_i,
    input  logic [3:0]      alu_flags_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [BITS-1:0] rsp_result_o,
    output logic [3:0]      rsp_flags_o,
    output logic            rsp_err_o
);

    localparam int CW = $clog2(BITS + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_MUL_ADD,
        S_MUL_SHIFT,
        S_RESP
    } state_t;

    state_t          r_state;
    logic [2:0]      r_op;
    // For mul, r_a doubles as the multiplicand and r_b as the multiplier.
    logic [BITS-1:0] r_a;
    logic [BITS-1:0] r_b;
    logic [BITS-1:0] r_acc;
    logic [CW-1:0]   r_count;

    logic            r_cmd_ready;
    logic            r_rsp_valid;
    logic [BITS-1:0] r_rsp_result;
    logic [3:0]      r_rsp_flags;
    logic            r_rsp_err;

    logic [BITS-1:0] w_alu_a;
    logic [BITS-1:0] w_alu_b;
    logic [2:0]      w_alu_op;

    // ALU drive is decoded from the state so it is zero whenever the
    // sequencer is idle, responding, or held in reset.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alu_op = '0;
        unique case (r_state)
            S_EXEC: begin
                w_alu_a  = r_a;
                w_alu_b  = r_b;
                w_alu_op = r_op;
            end
            S_MUL_ADD: begin
                w_alu_a  = r_acc;
                w_alu_b  = r_a;
                w_alu_op = OP_ADD;
            end
            S_MUL_SHIFT: begin
                w_alu_a  = r_a;
                w_alu_b  = BITS'(1);
                w_alu_op = OP_SHL;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_acc        <= '0;
            r_count      <= '0;
            r_cmd_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_op        <= cmd_op_i[2:0];
                        r_a         <= cmd_a_i;
                        r_b         <= cmd_b_i;
                        r_cmd_ready <= 1'b0;
                        if (!cmd_op_i[3]) begin
                            r_state <= S_EXEC;
                        end else if (cmd_op_i == 4'd8) begin
                            r_acc   <= '0;
                            r_count <= CW'(BITS);
                            r_state <= S_MUL_ADD;
                        end else begin
                            // Illegal opcode: answer right away with error.
                            r_rsp_valid  <= 1'b1;
                            r_rsp_result <= '0;
                            r_rsp_flags  <= '0;
                            r_rsp_err    <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_result <= alu_s_i;
                    r_rsp_flags  <= alu_flags_i;
                    r_rsp_err    <= 1'b0;
                    r_state      <= S_RESP;
                end
                S_MUL_ADD: begin
                    if (r_b[0]) begin
                        r_acc <= alu_s_i;
                    end
                    r_state <= S_MUL_SHIFT;
                end
                S_MUL_SHIFT: begin
                    r_a     <= alu_s_i;
                    r_b     <= r_b >> 1;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        // r_acc is final: the last add was the cycle before.
                        r_rsp_valid  <= 1'b1;
                        r_rsp_result <= r_acc;
                        r_rsp_flags  <= {r_acc[BITS-1], r_acc == '0, 2'b00};
                        r_rsp_err    <= 1'b0;
                        r_state      <= S_RESP;
                    end else begin
                        r_state <= S_MUL_ADD;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_result_o  = r_rsp_result;
    assign rsp_flags_o   = r_rsp_flags;
    assign rsp_err_o     = r_rsp_err;
    assign alu_a_o       = w_alu_a;
    assign alu_b_o       = w_alu_b;
    assign alu_control_o = {{(BITS-2){1'b0}}, w_alu_op};

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: bench ALU, transaction-level reference
// model with a per-cycle compare, and directed literal vectors.
module tb_alu_sequencer;

    localparam int B    = 4;
    localparam int MASK = (1 << B) - 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready_o;
    logic [3:0]   cmd_op = '0;
    logic [B-1:0] cmd_a = '0;
    logic [B-1:0] cmd_b = '0;
    logic [B-1:0] alu_a_o;
    logic [B-1:0] alu_b_o;
    logic [B:0]   alu_control_o;
    logic [B-1:0] alu_s;
    logic [3:0]   alu_flags;
    logic         rsp_valid_o;
    logic         rsp_ready = 1'b0;
    logic [B-1:0] rsp_result_o;
    logic [3:0]   rsp_flags_o;
    logic         rsp_err_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    alu_sequencer #(.BITS(B)) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op),
        .cmd_a_i(cmd_a),
        .cmd_b_i(cmd_b),
        .alu_a_o(alu_a_o),
        .alu_b_o(alu_b_o),
        .alu_control_o(alu_control_o),
        .alu_s_i(alu_s),
        .alu_flags_i(alu_flags),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready),
        .rsp_result_o(rsp_result_o),
        .rsp_flags_o(rsp_flags_o),
        .rsp_err_o(rsp_err_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: returns {flags N,Z,C,V, result}.
    function automatic logic [B+3:0] alu_fn(input logic [2:0] op,
                                           input logic [B-1:0] a,
                                           input logic [B-1:0] b);
        int s;
        logic c;
        logic v;
        logic [B-1:0] r;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                s = int'(a) + int'(b);
                r = B'(s);
                c = (s > MASK);
                v = (a[B-1] == b[B-1]) && (r[B-1] != a[B-1]);
            end
            3'd1: begin
                r = B'(int'(a) - int'(b));
                c = (a >= b);
                v = (a[B-1] != b[B-1]) && (r[B-1] != a[B-1]);
            end
            3'd2: r = B'((int'(a) << b) & MASK);
            3'd3: r = a >> b;
            3'd4: r = a | b;
            3'd5: r = a & b;
            3'd6: r = a ^ b;
            default: r = ~a;
        endcase
        return {r[B-1], r == '0, c, v, r};
    endfunction

    logic [B+3:0] w_alu;
    assign w_alu     = alu_fn(alu_control_o[2:0], alu_a_o, alu_b_o);
    assign alu_s     = w_alu[B-1:0];
    assign alu_flags = w_alu[B+3:B];

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction, response due a fixed
    // number of cycles after the accepting cycle.
    bit           m_busy = 1'b0;
    int           m_t = 0;
    int           m_lat = 0;
    logic [3:0]   m_op = '0;
    logic [B-1:0] m_a = '0;
    logic [B-1:0] m_b = '0;
    logic [B-1:0] m_res = '0;
    logic [3:0]   m_flg = '0;
    logic         m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [B+3:0] r;
        if (!rst_n) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1'b1;
                m_t    = cyc;
                m_op   = cmd_op;
                m_a    = cmd_a;
                m_b    = cmd_b;
                m_err  = 1'b0;
                if (cmd_op < 4'd8) begin
                    r     = alu_fn(cmd_op[2:0], cmd_a, cmd_b);
                    m_res = r[B-1:0];
                    m_flg = r[B+3:B];
                    m_lat = 2;
                end else if (cmd_op == 4'd8) begin
                    m_res = B'((int'(cmd_a) * int'(cmd_b)) & MASK);
                    m_flg = {m_res[B-1], m_res == '0, 2'b00};
                    m_lat = 2 * B + 1;
                end else begin
                    m_res = '0;
                    m_flg = '0;
                    m_err = 1'b1;
                    m_lat = 1;
                end
            end
        end else if ((cyc - m_t) >= m_lat && rsp_ready) begin
            m_busy = 1'b0;
        end
    end

    always @(negedge clk) begin
        int off;
        if (!m_busy) begin
            chk("idle_ready", cmd_ready_o, 1);
            chk("idle_valid", rsp_valid_o, 0);
            chk("idle_alu_ctl", alu_control_o, 0);
            chk("idle_alu_a", alu_a_o, 0);
            chk("idle_alu_b", alu_b_o, 0);
        end else begin
            off = cyc - m_t;
            chk("busy_ready", cmd_ready_o, 0);
            chk("valid", rsp_valid_o, int'(off >= m_lat));
            if (off >= m_lat) begin
                chk("result", rsp_result_o, m_res);
                chk("flags", rsp_flags_o, m_flg);
                chk("err", rsp_err_o, m_err);
                chk("resp_alu_ctl", alu_control_o, 0);
                chk("resp_alu_a", alu_a_o, 0);
            end else if (m_op == 4'd8) begin
                if (off % 2 == 1) begin
                    chk("mul_add_ctl", alu_control_o, 0);
                    chk("mul_add_b", alu_b_o,
                        (int'(m_a) << ((off - 1) / 2)) & MASK);
                end else begin
                    chk("mul_shl_ctl", alu_control_o, 2);
                    chk("mul_shl_a", alu_a_o,
                        (int'(m_a) << (off / 2 - 1)) & MASK);
                    chk("mul_shl_b", alu_b_o, 1);
                end
            end else begin
                chk("exec_ctl", alu_control_o, m_op);
                chk("exec_a", alu_a_o, m_a);
                chk("exec_b", alu_b_o, m_b);
            end
        end
    end

    task automatic run(input string nm, input logic [3:0] op,
                       input logic [B-1:0] a, input logic [B-1:0] b,
                       input int hold, input int e_lat, input int e_res,
                       input int e_flg, input int e_err);
        int t;
        int lat;
        bit seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        t         = cyc;
        seen      = 1'b0;
        lat       = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (rsp_valid_o) begin
                seen = 1'b1;
                lat  = cyc - t;
            end
        end
        cmd_valid = 1'b0;
        chk({nm, "_seen"}, seen, 1);
        if (!seen) return;
        chk({nm, "_lat"}, lat, e_lat);
        chk({nm, "_res"}, rsp_result_o, e_res);
        chk({nm, "_flg"}, rsp_flags_o, e_flg);
        chk({nm, "_err"}, rsp_err_o, e_err);
        // Commands offered while busy must be ignored.
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = 4'd0;
            @(negedge clk);
            chk({nm, "_hold_ready"}, cmd_ready_o, 0);
            chk({nm, "_hold_res"}, rsp_result_o, e_res);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_ready_after"}, cmd_ready_o, 1);
        chk({nm, "_valid_after"}, rsp_valid_o, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready_o, 1);
        chk("rst_valid", rsp_valid_o, 0);
        chk("rst_res", rsp_result_o, 0);
        chk("rst_flg", rsp_flags_o, 0);
        chk("rst_err", rsp_err_o, 0);
        chk("rst_ctl", alu_control_o, 0);
        #2 rst_n = 1'b1;

        run("add_7_5",  4'd0, 4'h7, 4'h5, 0, 2, 'hC, 'b1001, 0);
        run("mul_3_5",  4'd8, 4'h3, 4'h5, 0, 9, 'hF, 'b1000, 0);
        run("mul_4_4",  4'd8, 4'h4, 4'h4, 0, 9, 'h0, 'b0100, 0);
        run("ill_A",    4'hA, 4'h3, 4'h3, 0, 1, 'h0, 'b0000, 1);
        run("sub_hold", 4'd1, 4'h9, 4'h3, 5, 2, 'h6, 'b0011, 0);
        run("sub_neg",  4'd1, 4'h3, 4'h5, 0, 2, 'hE, 'b1000, 0);
        run("shl",      4'd2, 4'h3, 4'h2, 0, 2, 'hC, 'b1000, 0);
        run("shr",      4'd3, 4'hC, 4'h2, 0, 2, 'h3, 'b0000, 0);
        run("or",       4'd4, 4'h5, 4'hA, 0, 2, 'hF, 'b1000, 0);
        run("and",      4'd5, 4'h5, 4'hA, 0, 2, 'h0, 'b0100, 0);
        run("xor",      4'd6, 4'h6, 4'h3, 0, 2, 'h5, 'b0000, 0);
        run("not",      4'd7, 4'h5, 4'h0, 0, 2, 'hA, 'b1000, 0);
        run("mul_7_7",  4'd8, 4'h7, 4'h7, 0, 9, 'h1, 'b0000, 0);
        run("mul_F_F",  4'd8, 4'hF, 4'hF, 0, 9, 'h1, 'b0000, 0);
        run("mul_2_0",  4'd8, 4'h2, 4'h0, 0, 9, 'h0, 'b0100, 0);
        run("ill_F",    4'hF, 4'h1, 4'h1, 0, 1, 'h0, 'b0000, 1);

        // Reset pulse during the first MUL_SHIFT cycle.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd8;
        cmd_a     = 4'h3;
        cmd_b     = 4'h5;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_ready", cmd_ready_o, 1);
        chk("mrst_valid", rsp_valid_o, 0);
        chk("mrst_res", rsp_result_o, 0);
        chk("mrst_flg", rsp_flags_o, 0);
        chk("mrst_err", rsp_err_o, 0);
        chk("mrst_ctl", alu_control_o, 0);
        chk("mrst_a", alu_a_o, 0);
        chk("mrst_b", alu_b_o, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("post_rst_valid", rsp_valid_o, 0);
        end
        run("add_2_3", 4'd0, 4'h2, 4'h3, 0, 2, 'h5, 'b0000, 0);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter BITS, default 4: operand and result width, legal range 3..16.
REQ-002 SHALL have port clk_i, input, 1: the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_valid_i, input, 1: command offered.
REQ-005 SHALL have port cmd_ready_o, output, 1: command accepted when high with cmd_valid_i.
REQ-006 SHALL have port cmd_op_i, input, 4: 0 add, 1 sub, 2 shl, 3 shr, 4 or, 5 and, 6 xor, 7 not, 8 mul, 9-15 illegal.
REQ-007 SHALL have ports cmd_a_i and cmd_b_i, input, BITS each: operands.
REQ-008 SHALL have ports alu_a_o and alu_b_o, output, BITS each: operands to the external combinational ALU.
REQ-009 SHALL have port alu_control_o, output, BITS+1: ALU op select, 3-bit code zero-extended.
REQ-010 SHALL have port alu_s_i, input, BITS: ALU result, valid in the same cycle the ALU inputs are driven.
REQ-011 SHALL have port alu_flags_i, input, 4: ALU flags {N,Z,C,V}.
REQ-012 SHALL have port rsp_valid_o, output, 1: response available.
REQ-013 SHALL have port rsp_ready_i, input, 1: response consumed when high with rsp_valid_o.
REQ-014 SHALL have ports rsp_result_o (BITS), rsp_flags_o (4, {N,Z,C,V}) and rsp_err_o (1), all outputs: response payload.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, MUL_ADD, MUL_SHIFT, RESP.
REQ-016 SHALL drive cmd_ready_o high only in IDLE; a handshake in cycle T latches op, a and b.
REQ-017 SHALL, for ops 0-7, move IDLE->EXEC; EXEC drives alu_a_o=a, alu_b_o=b, alu_control_o=op, captures alu_s_i and alu_flags_i, then moves to RESP; rsp_valid_o rises in T+2.
REQ-018 SHALL, for op 8, initialise acc=0, mcand=a, mplier=b and count=BITS, then alternate MUL_ADD and MUL_SHIFT for exactly BITS iterations; rsp_valid_o rises in T+2*BITS+1.
REQ-019 SHALL, in MUL_ADD, drive ALU add(acc, mcand) and load acc from alu_s_i only when mplier[0]=1; otherwise acc is held, and the state always takes one cycle.
REQ-020 SHALL, in MUL_SHIFT, drive ALU shl(mcand, 1), load mcand from alu_s_i, shift mplier right by one internally, and decrement count; at count reaching 0 go to RESP, otherwise go to MUL_ADD.
REQ-021 SHALL return the product modulo 2^BITS for mul, with flags {acc[BITS-1], acc==0, 0, 0}; ALU flags are ignored for mul.
REQ-022 SHALL, for ops 9-15, go IDLE->RESP with rsp_err_o=1, rsp_result_o=0 and rsp_flags_o=0, so that rsp_valid_o rises in T+1; rsp_err_o=0 for all legal ops.
REQ-023 SHALL hold rsp_valid_o and the payload stable in RESP until rsp_ready_i=1, then return to IDLE; the next command is accepted no earlier than the following cycle.
REQ-024 SHALL drive alu_a_o, alu_b_o and alu_control_o to 0 in IDLE and RESP.
REQ-025 SHALL ignore cmd_valid_i outside IDLE and never drop or duplicate a response.

Reset
REQ-026 SHALL, while rst_n_i=0, force state IDLE, rsp_valid_o=0, rsp_result_o=0, rsp_flags_o=0, rsp_err_o=0, all ALU outputs 0, and cmd_ready_o=1, independent of clk_i.
REQ-027 SHALL, on reset asserted mid-operation, discard the operation and produce no response after release.

Verification
REQ-028 SHALL cover: BITS=4, add a=7 b=5 with a bench ALU model -> alu_control_o=0 in T+1; rsp_result_o=0xC, flags equal to the model's flags, rsp_valid_o in T+2.
REQ-029 SHALL cover: mul a=3 b=5 -> rsp_result_o=0xF, rsp_flags_o=4'b1000, rsp_valid_o in T+9.
REQ-030 SHALL cover: mul a=4 b=4 -> rsp_result_o=0x0, rsp_flags_o=4'b0100 (wrap-around).
REQ-031 SHALL cover: op=0xA -> rsp_valid_o in T+1, rsp_err_o=1, result 0, flags 0.
REQ-032 SHALL cover: rsp_ready_i held low for 5 cycles after a sub -> payload stable, cmd_ready_o=0 throughout; after the handshake, cmd_ready_o=1 the next cycle.
REQ-033 SHALL cover: rst_n_i pulsed low during MUL_SHIFT -> outputs at reset values immediately, no rsp_valid_o after release, and a new add completes normally.
